// File: rtl/jtgng_romload_pkg.sv
// Shared types for the ROM download sequencer: FSM states and the packed
// SDRAM word that travels through the FIFO.
package jtgng_romload_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN,
    HOLD
  } state_t;

  // Widest word address the 25-bit byte address can produce; ports truncate to AW.
  localparam int WADDR_W = 24;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [15:0]        data;
    logic [1:0]         be;
  } word_t;

endpackage

// File: rtl/jtgng_romload_fifo.sv
// Small synchronous FIFO of SDRAM words. A push while full is ignored; the
// caller watches full to flag the loss.
module jtgng_romload_fifo
  import jtgng_romload_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  word_t                  push_word,
  input  logic                   pop,
  output word_t                  pop_word,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          wr_en;
  logic          rd_en;

  assign full     = (count_reg == (PW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_word = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (wr_en && !rd_en)      count_reg <= count_reg + (PW+1)'(1);
      else if (!wr_en && rd_en) count_reg <= count_reg - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/jtgng_romload_ctrl.sv
// ROM download sequencer: packs hps_io byte strobes into 16-bit SDRAM writes,
// holds the game core in reset until the last write lands plus a guard time.
module jtgng_romload_ctrl
  import jtgng_romload_pkg::*;
#(
  parameter int          AW         = 22,
  parameter int          FIFO_DEPTH = 4,
  parameter int          POST_RST   = 16,
  parameter logic [31:0] SIG        = 32'h10830080
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          sdram_req,
  input  logic          sdram_ack,
  output logic [AW-1:0] sdram_addr,
  output logic [15:0]   sdram_data,
  output logic [1:0]    sdram_be,
  output logic          game_rst,
  output logic          inv_ena,
  output logic          overflow
);
  localparam int CW = $clog2(POST_RST + 1);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  state_t               state_reg;
  logic                 dl_reg;
  logic                 latch_valid_reg;
  logic [WADDR_W-1:0]   latch_addr_reg;
  logic [7:0]           latch_byte_reg;
  logic                 skid_valid_reg;
  word_t                skid_reg;
  logic [3:0]           flag_reg;
  logic [CW-1:0]        hold_cnt_reg;

  logic                 dl_rise, dl_fall, byte_wr, odd, sig_hit;
  logic [WADDR_W-1:0]   waddr;
  logic [7:0]           sig_byte [4];
  word_t                partial_word;
  logic [2:0]           cand_v;
  word_t                cand_w [3];
  logic                 fifo_push, fifo_full, fifo_empty, skid_next_v, cand_drop, done;
  word_t                fifo_in, fifo_out, skid_next_w;
  logic [NW-1:0]        fifo_count;
  logic                 unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sig
      assign sig_byte[gi] = SIG[31-8*gi -: 8];
    end
  endgenerate

  assign dl_rise      = ioctl_download && !dl_reg;
  assign dl_fall      = !ioctl_download && dl_reg;
  assign byte_wr      = ioctl_wr && ioctl_download;
  assign odd          = ioctl_addr[0];
  assign waddr        = WADDR_W'(ioctl_addr[AW:1]);
  assign sig_hit      = (ioctl_dout == sig_byte[ioctl_addr[1:0]]);
  assign partial_word = '{addr: latch_addr_reg, data: {8'h00, latch_byte_reg}, be: 2'b01};
  assign done         = fifo_empty && !skid_valid_reg && !sdram_req;
  assign unused_bits  = ^{ioctl_addr[24:AW+1], fifo_count, fifo_out.addr[WADDR_W-1:AW]};

  // Up to three words may want the FIFO in one cycle, oldest first: skid, then this strobe's pair.
  always_comb begin
    cand_v    = 3'b000;
    cand_w[0] = skid_reg;
    cand_w[1] = partial_word;
    cand_w[2] = partial_word;
    cand_v[0] = skid_valid_reg;
    if (byte_wr) begin
      if (!odd) begin
        cand_v[1] = latch_valid_reg;
      end else if (latch_valid_reg && latch_addr_reg == waddr) begin
        cand_v[1] = 1'b1;
        cand_w[1] = '{addr: waddr, data: {ioctl_dout, latch_byte_reg}, be: 2'b11};
      end else begin
        cand_v[1] = latch_valid_reg;
        cand_v[2] = 1'b1;
        cand_w[2] = '{addr: waddr, data: {ioctl_dout, 8'h00}, be: 2'b10};
      end
    end else if (state_reg == FLUSH) begin
      cand_v[1] = latch_valid_reg;
    end
  end

  always_comb begin
    fifo_push   = 1'b0;
    fifo_in     = cand_w[0];
    skid_next_v = 1'b0;
    skid_next_w = skid_reg;
    cand_drop   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (cand_v[i]) begin
        if (!fifo_push) begin
          fifo_push = 1'b1;
          fifo_in   = cand_w[i];
        end else if (!skid_next_v) begin
          skid_next_v = 1'b1;
          skid_next_w = cand_w[i];
        end else begin
          cand_drop = 1'b1;
        end
      end
    end
  end

  jtgng_romload_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_word (fifo_in),
    .pop       (!sdram_req),
    .pop_word  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      dl_reg          <= 1'b0;
      latch_valid_reg <= 1'b0;
      latch_addr_reg  <= '0;
      latch_byte_reg  <= '0;
      skid_valid_reg  <= 1'b0;
      skid_reg        <= '0;
      flag_reg        <= '0;
      hold_cnt_reg    <= '0;
      sdram_req       <= 1'b0;
      sdram_addr      <= '0;
      sdram_data      <= '0;
      sdram_be        <= '0;
      game_rst        <= 1'b1;
      inv_ena         <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      dl_reg         <= ioctl_download;
      skid_valid_reg <= skid_next_v;
      skid_reg       <= skid_next_w;

      if (byte_wr) begin
        latch_valid_reg <= !odd;
        if (!odd) begin
          latch_addr_reg <= waddr;
          latch_byte_reg <= ioctl_dout;
        end
      end else if (state_reg == FLUSH) begin
        latch_valid_reg <= 1'b0;
      end

      if (dl_rise) overflow <= 1'b0;
      else if (cand_drop || (fifo_push && fifo_full)) overflow <= 1'b1;

      if (dl_rise) begin
        flag_reg <= '0;
        inv_ena  <= 1'b0;
      end else begin
        if (byte_wr && ioctl_addr[AW:2] == '0) flag_reg[ioctl_addr[1:0]] <= sig_hit;
        inv_ena <= &flag_reg;
      end

      if (sdram_req) begin
        if (sdram_ack) sdram_req <= 1'b0;
      end else if (!fifo_empty) begin
        sdram_req  <= 1'b1;
        sdram_addr <= fifo_out.addr[AW-1:0];
        sdram_data <= fifo_out.data;
        sdram_be   <= fifo_out.be;
      end

      // Guard time is measured from the last ack, so an early final ack is not padded twice.
      if (dl_rise || (sdram_req && sdram_ack)) hold_cnt_reg <= '0;
      else if (hold_cnt_reg != CW'(POST_RST)) hold_cnt_reg <= hold_cnt_reg + CW'(1);

      if (dl_rise) begin
        state_reg <= LOAD;
        game_rst  <= 1'b1;
      end else begin
        case (state_reg)
          IDLE:  game_rst <= 1'b0;
          LOAD:  if (dl_fall) state_reg <= FLUSH;
          FLUSH: state_reg <= DRAIN;
          DRAIN: if (done) state_reg <= HOLD;
          HOLD: begin
            if (hold_cnt_reg >= CW'(POST_RST - 1)) begin
              state_reg <= IDLE;
              game_rst  <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtgng_romload_ctrl.sv
// Directed and randomized bench for the ROM download sequencer, checked
// against a byte-to-word packing model built from the download byte list.
module tb_jtgng_romload_ctrl;
  localparam int          AW    = 22;
  localparam int          DEPTH = 4;
  localparam int          POST  = 16;
  localparam logic [31:0] SIG   = 32'h10830080;
  localparam logic [24:0] MASK  = 25'h7FFFFF;

  typedef struct packed {
    logic [24:0] a;
    logic [7:0]  d;
  } bw_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ioctl_download, ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          sdram_req, sdram_ack;
  logic [AW-1:0] sdram_addr;
  logic [15:0]   sdram_data;
  logic [1:0]    sdram_be;
  logic          game_rst, inv_ena, overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bw_t         bw_q[$];
  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];
  bit          ack_en = 1'b1;
  int          ack_delay = 2;
  int          dly = 0;
  int          last_ack_cyc = 0;
  int          stab_err = 0;
  bit          prev_req = 1'b0;
  logic [41:0] prev_word = '0;

  jtgng_romload_ctrl #(.AW(AW), .FIFO_DEPTH(DEPTH), .POST_RST(POST), .SIG(SIG)) dut (
    .clk            (clk),
    .rst            (rst),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .sdram_req      (sdram_req),
    .sdram_ack      (sdram_ack),
    .sdram_addr     (sdram_addr),
    .sdram_data     (sdram_data),
    .sdram_be       (sdram_be),
    .game_rst       (game_rst),
    .inv_ena        (inv_ena),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM side: acks each request after ack_delay cycles, logs writes, watches stability.
  always @(negedge clk) begin
    logic [41:0] cur;
    cur = {24'(sdram_addr), sdram_data, sdram_be};
    if (prev_req && sdram_req && cur !== prev_word) stab_err++;
    prev_req  = sdram_req;
    prev_word = cur;
    if (sdram_ack) begin
      sdram_ack = 1'b0;
    end else if (ack_en && sdram_req) begin
      if (dly >= ack_delay) begin
        sdram_ack = 1'b1;
        got_q.push_back(cur);
        $display("write addr=%06h data=%04h be=%02b", cur[41:18], cur[17:2], cur[1:0]);
        last_ack_cyc = cyc + 1;
        dly = 0;
      end else begin
        dly++;
      end
    end else begin
      dly = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packing rules applied to the whole byte list of one download.
  function automatic void build_exp();
    bit          have = 1'b0;
    logic [23:0] pa = '0;
    logic [7:0]  pd = '0;
    logic [23:0] wa;
    exp_q.delete();
    foreach (bw_q[i]) begin
      wa = 24'((bw_q[i].a & MASK) >> 1);
      if (!bw_q[i].a[0]) begin
        if (have) exp_q.push_back({pa, 8'h00, pd, 2'b01});
        have = 1'b1;
        pa = wa;
        pd = bw_q[i].d;
      end else if (have && pa == wa) begin
        exp_q.push_back({wa, bw_q[i].d, pd, 2'b11});
        have = 1'b0;
      end else begin
        if (have) exp_q.push_back({pa, 8'h00, pd, 2'b01});
        exp_q.push_back({wa, bw_q[i].d, 8'h00, 2'b10});
        have = 1'b0;
      end
    end
    if (have) exp_q.push_back({pa, 8'h00, pd, 2'b01});
  endfunction

  function automatic logic exp_inv();
    logic [3:0]  f = '0;
    logic [24:0] a;
    foreach (bw_q[i]) begin
      a = bw_q[i].a & MASK;
      if (a < 25'd4) f[a[1:0]] = (bw_q[i].d == 8'(SIG >> (8 * (3 - int'(a[1:0])))));
    end
    return &f;
  endfunction

  task automatic start_dl();
    @(negedge clk);
    ioctl_download = 1'b1;
    bw_q.delete();
    got_q.delete();
    stab_err = 0;
  endtask

  task automatic end_dl();
    @(negedge clk);
    ioctl_download = 1'b0;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input int gap);
    @(negedge clk);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    bw_q.push_back('{a: a, d: d});
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    while (game_rst !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n >= 2000), 64'd0);
    chk({tag, "_rel_cycles"}, 64'(cyc - last_ack_cyc), 64'(POST));
  endtask

  task automatic check_writes(input string tag, input int limit);
    build_exp();
    if (limit >= 0) while (exp_q.size() > limit) void'(exp_q.pop_back());
    chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    chk({tag, "_stable"}, 64'(stab_err), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    sdram_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", 64'(sdram_req), 64'd0);
    chk("rst_addr", 64'(sdram_addr), 64'd0);
    chk("rst_data", 64'(sdram_data), 64'd0);
    chk("rst_be", 64'(sdram_be), 64'd0);
    chk("rst_game_rst", 64'(game_rst), 64'd1);
    chk("rst_inv_ena", 64'(inv_ena), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_game_rst", 64'(game_rst), 64'd0);

    // Signature download, ack two cycles after each request.
    ack_delay = 2;
    start_dl();
    wr_byte(25'd0, 8'h10, 3); wr_byte(25'd1, 8'h83, 3); wr_byte(25'd2, 8'h00, 3);
    wr_byte(25'd3, 8'h80, 3); wr_byte(25'd4, 8'hAA, 3); wr_byte(25'd5, 8'hBB, 3);
    end_dl();
    wait_release("sig");
    check_writes("sig", -1);
    chk("sig_w0_const", 64'(got_q.size() > 0 ? got_q[0] : 42'h0), 64'({24'd0, 16'h8310, 2'b11}));
    chk("sig_inv_ena", 64'(inv_ena), 64'(exp_inv()));
    chk("sig_inv_ena_const", 64'(inv_ena), 64'd1);
    chk("sig_overflow", 64'(overflow), 64'd0);

    // Odd-length download leaves a trailing partial word for FLUSH.
    start_dl();
    wr_byte(25'd0, 8'h00, 3); wr_byte(25'd1, 8'h11, 3); wr_byte(25'd2, 8'h22, 3);
    end_dl();
    wait_release("odd");
    check_writes("odd", -1);
    chk("odd_w1_const", 64'(got_q.size() > 1 ? got_q[1] : 42'h0), 64'({24'd1, 16'h0022, 2'b01}));

    // Stalled SDRAM: FIFO fills, later words are lost, nothing duplicates.
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 12; i++) wr_byte(25'(i), 8'($urandom), 2);
    repeat (16) @(negedge clk);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_req_held", 64'(sdram_req), 64'd1);
    end_dl();
    ack_en = 1'b1;
    wait_release("ovf");
    check_writes("ovf", DEPTH + 1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Odd byte before its even partner: two partial writes to the same word.
    start_dl();
    wr_byte(25'd3, 8'hDD, 3); wr_byte(25'd2, 8'hEE, 3);
    end_dl();
    wait_release("ooo");
    check_writes("ooo", -1);
    chk("ooo_w0_const", 64'(got_q.size() > 0 ? got_q[0] : 42'h0), 64'({24'd1, 16'hDD00, 2'b10}));
    chk("ooo_inv_ena", 64'(inv_ena), 64'd0);

    // Reset while a request is pending in DRAIN.
    ack_en = 1'b0;
    start_dl();
    for (int i = 0; i < 12; i++) wr_byte(25'(i), 8'($urandom), 2);
    end_dl();
    repeat (3) @(negedge clk);
    chk("rstd_pre_req", 64'(sdram_req), 64'd1);
    chk("rstd_pre_ovf", 64'(overflow), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstd_req", 64'(sdram_req), 64'd0);
    chk("rstd_game_rst", 64'(game_rst), 64'd1);
    chk("rstd_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    ack_en = 1'b1;
    got_q.delete();
    repeat (30) @(negedge clk);
    chk("rstd_fifo_empty", 64'(got_q.size()), 64'd0);
    chk("rstd_req_idle", 64'(sdram_req), 64'd0);

    // New download arriving during HOLD.
    start_dl();
    wr_byte(25'd0, 8'h10, 3); wr_byte(25'd1, 8'h83, 3);
    wr_byte(25'd2, 8'h00, 3); wr_byte(25'd3, 8'h80, 3);
    end_dl();
    for (int n = 0; n < 200 && got_q.size() < 2; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("hold_game_rst", 64'(game_rst), 64'd1);
    chk("hold_inv_ena", 64'(inv_ena), 64'd1);
    start_dl();
    @(negedge clk);
    chk("redl_inv_ena", 64'(inv_ena), 64'd0);
    chk("redl_game_rst", 64'(game_rst), 64'd1);
    wr_byte(25'd0, 8'h10, 3); wr_byte(25'd1, 8'h55, 3);
    end_dl();
    wait_release("redl");
    check_writes("redl", -1);
    chk("redl_inv_after", 64'(inv_ena), 64'(exp_inv()));

    // Random addresses (including aliases above the SDRAM size) and random ack delay.
    for (int r = 0; r < 4; r++) begin
      int nb;
      ack_delay = $urandom_range(0, 3);
      nb = $urandom_range(4, 12);
      start_dl();
      for (int i = 0; i < nb; i++)
        wr_byte((25'($urandom_range(0, 3)) << 23) | 25'($urandom_range(0, 7)), 8'($urandom), 14);
      end_dl();
      wait_release($sformatf("rnd%0d", r));
      check_writes($sformatf("rnd%0d", r), -1);
      chk($sformatf("rnd%0d_inv", r), 64'(inv_ena), 64'(exp_inv()));
      chk($sformatf("rnd%0d_ovf", r), 64'(overflow), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtgng_romload_ctrl.md
Name: jtgng_romload_ctrl

Overview:
- Sequences the ROM download stream from the HPS I/O block into the SDRAM write port.
- Packs byte writes into 16-bit words and queues them in a small FIFO, then issues SDRAM write requests with a req/ack handshake.
- Holds the game core in reset until every queued word has been written, plus a fixed guard time.
- Sits between hps_io and the SDRAM controller. It replaces the ad-hoc download reset and ROM signature detection in the MiSTer top level.

Parameters:
- AW, 22: SDRAM word-address width.
- FIFO_DEPTH, 4: word FIFO entries; must be a power of two and at least 2.
- POST_RST, 16: cycles game_rst stays high after the final write is acknowledged.
- SIG, 32'h10830080: expected bytes 0..3 of the ROM (byte 0 is the MSB), used for the inv_ena flag.

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- sdram_req  out  1  write request; level signal.
- sdram_ack  in  1  one-cycle acknowledge of the current request.
- sdram_addr  out  AW  word address (byte address >> 1).
- sdram_data  out  16  {odd byte, even byte}.
- sdram_be  out  2  byte enables; bit 1 = odd byte.
- game_rst  out  1  reset to the game core.
- inv_ena  out  1  signature matched.
- overflow  out  1  sticky flag: a byte was lost because the FIFO was full.

Behaviour:
- Reset values: sdram_req=0, sdram_addr=0, sdram_data=0, sdram_be=0, game_rst=1, inv_ena=0, overflow=0. FIFO is empty, byte latch is invalid, state is IDLE.
- States and transitions:
  - IDLE to LOAD on a rising edge of ioctl_download.
  - LOAD to FLUSH on a falling edge of ioctl_download.
  - FLUSH to DRAIN after at most one cycle.
  - DRAIN to HOLD when the FIFO is empty and no request is outstanding.
  - HOLD to IDLE after POST_RST cycles.
  - Any state to LOAD when ioctl_download rises again; the HOLD counter and the signature flags are cleared.
- game_rst is 1 in LOAD, FLUSH, DRAIN and HOLD, and 0 only in IDLE. game_rst deasserts exactly POST_RST cycles after the last ack.
- Byte packing, on each ioctl_wr:
  - Even address: latch {addr[24:1], byte} and mark the latch valid. If the latch was already valid, first push it as a partial word with be=2'b01.
  - Odd address matching the latched word address: push {byte, latched byte}, be=2'b11, and clear the latch.
  - Odd address not matching: first push any valid latch (be=01), then push {byte, 8'h00} with be=2'b10.
  - At most two pushes occur per strobe. The second push is held in a one-entry skid register and enters the FIFO on the next cycle.
- In FLUSH, a valid latch is pushed with be=01.
- FIFO:
  - A push while full drops the word and sets overflow.
  - overflow clears only on rst or a new download start.
  - A push and a pop in the same cycle are both honoured, and the count is unchanged.
- SDRAM handshake:
  - When the FIFO is non-empty and sdram_req=0, pop the head onto addr/data/be and assert sdram_req on the next cycle.
  - Hold sdram_req, addr, data and be stable until sdram_ack is sampled high; drop sdram_req in that same edge.
  - Minimum gap between requests is one cycle.
  - An ack while sdram_req=0 is ignored.
- Signature:
  - Byte writes to addresses 0..3 compare against the corresponding SIG byte and set or clear flag[i].
  - inv_ena is the registered AND of all four flags.
  - inv_ena updates continuously and survives the end of the download. It is cleared by rst or a new download.
- Address wrap: ioctl_addr beyond 2^(AW+1) bytes truncates silently; upper bits are ignored.
- Reset mid-download: all state returns to the reset values, and in-flight requests are abandoned. sdram_req drops on the next edge.

Decomposition:
- Package jtgng_romload_pkg holds:
  - the state enum typedef (IDLE, LOAD, FLUSH, DRAIN, HOLD);
  - the word struct typedef {addr, data, be}.
- One sub-module, jtgng_romload_fifo: a synchronous FIFO of the word struct with full/empty/count, parameterized by FIFO_DEPTH.

Test Plan:
- Bytes 10,83,00,80,AA,BB at addresses 0..5, with ack 2 cycles after each req:
  - required writes are addr0=8310, addr1=8000, addr2=BBAA, all with be=11;
  - inv_ena=1, and game_rst falls 16 cycles after the third ack.
- Odd-length download of 3 bytes (00,11,22):
  - second write is addr1 data=0022 be=01, issued in FLUSH;
  - game_rst is held until that write is acked plus 16 cycles.
- ack held low for 40 cycles while 12 bytes stream every 2 cycles:
  - FIFO fills and overflow=1;
  - sdram_addr/data stay stable while req=1, and no write is duplicated.
- Out-of-order bytes (addr 3 then addr 2):
  - writes are addr1 data=DD00 be=10, then addr1 be=01;
  - inv_ena=0.
- rst asserted in DRAIN with req=1: next cycle req=0, game_rst=1, overflow=0, and the FIFO is empty.
- New download rising edge during HOLD: state returns to LOAD, the counter restarts, and inv_ena clears.
